// File: rtl/viterbi_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_ctrl_gen
// Description : Control and traceback unit for a rate-1/2 (2,1,K) hard-decision
//               Viterbi decoder. Sequences an external ACS array, stores the
//               survivor metrics and decision bits, picks the best state and
//               traces back T columns to emit one decoded bit per symbol.
//               Optional macro VITERBI_METRIC_NORM_EN subtracts the minimum
//               incoming metric before storing.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_ctrl_gen #(
    parameter int K         = 3,
    parameter int W         = 4,
    parameter int T         = 16,
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = 9
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic                        sym_valid,
    output logic                        sym_ready,
    output logic                        le,
    output logic                        ae,
    input  logic [(2**(K-1))*W-1:0]     acs_metric_in,
    input  logic [(2**(K-1))-1:0]       acs_dec_in,
    output logic [(2**(K-1))*W-1:0]     metric_out,
    output logic                        dx,
    output logic                        dx_valid,
    input  logic                        dx_ready,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int M     = K - 1;
    localparam int NS    = 1 << M;
    localparam int PTR_W = (T > 1) ? $clog2(T) : 1;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_WAIT_SYM = 3'd1;
    localparam logic [2:0] c_ST_LOAD     = 3'd2;
    localparam logic [2:0] c_ST_ADD      = 3'd3;
    localparam logic [2:0] c_ST_WRITE    = 3'd4;
    localparam logic [2:0] c_ST_BEST     = 3'd5;
    localparam logic [2:0] c_ST_TRACE    = 3'd6;
    localparam logic [2:0] c_ST_OUTPUT   = 3'd7;

    localparam logic [PTR_W-1:0] c_PTR_LAST  = PTR_W'(T - 1);
    localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_T_CNT     = CNT_W'(T);
    localparam logic [CNT_W-1:0] c_FRAME_CNT = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    // Encoder starts in state 0: that state is free, every other one is "infinitely" bad
    localparam logic [NS*W-1:0]  c_METRIC_INIT = {{((NS-1)*W){1'b1}}, {W{1'b0}}};

    logic [2:0]        state_q, state_d;
    logic [NS*W-1:0]   metric_q, metric_d;
    logic [NS-1:0]     col_q [T];
    logic [NS-1:0]     col_d [T];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  trace_cnt_q, trace_cnt_d;
    logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic [M-1:0]      tb_state_q, tb_state_d;
    logic              frame_done_q, frame_done_d;

    logic [CNT_W-1:0]  sym_cnt_inc;
    logic [NS*W-1:0]   metric_wr;
    logic [M-1:0]      best_idx;
    logic [W-1:0]      best_val;
    logic              trace_dec;
    logic [M:0]        tb_shift;

    assign sym_cnt_inc = sym_cnt_q + c_CNT_ONE;
    // Predecessor = decision bit shifted in as the oldest bit, newest bit drops out
    assign trace_dec   = col_q[rd_ptr_q][tb_state_q];
    assign tb_shift    = {trace_dec, tb_state_q};

`ifdef VITERBI_METRIC_NORM_EN
    logic [W-1:0] acs_min;
    // Rebase incoming metrics so the smallest stored metric is always zero
    always_comb begin
        acs_min = acs_metric_in[W-1:0];
        for (int s = 1; s < NS; s++) begin
            if (acs_metric_in[s*W +: W] < acs_min) begin
                acs_min = acs_metric_in[s*W +: W];
            end
        end
        metric_wr = acs_metric_in;
        for (int s = 0; s < NS; s++) begin
            metric_wr[s*W +: W] = acs_metric_in[s*W +: W] - acs_min;
        end
    end
`else
    // Metrics are stored as delivered; saturation is the ACS array's job
    always_comb begin
        metric_wr = acs_metric_in;
    end
`endif

    // Minimum stored metric; strict compare keeps the lowest index on ties
    always_comb begin
        best_idx = '0;
        best_val = metric_q[W-1:0];
        for (int s = 1; s < NS; s++) begin
            if (metric_q[s*W +: W] < best_val) begin
                best_val = metric_q[s*W +: W];
                best_idx = M'(s);
            end
        end
    end

    // State register plus all datapath flops
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= c_ST_IDLE;
            metric_q     <= c_METRIC_INIT;
            for (int c = 0; c < T; c++) begin
                col_q[c] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            trace_cnt_q  <= '0;
            sym_cnt_q    <= '0;
            tb_state_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            metric_q     <= metric_d;
            col_q        <= col_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            trace_cnt_q  <= trace_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            tb_state_q   <= tb_state_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:     if (frame_start) state_d = c_ST_WAIT_SYM;
            c_ST_WAIT_SYM: if (sym_valid) state_d = c_ST_LOAD;
            c_ST_LOAD:     state_d = c_ST_ADD;
            c_ST_ADD:      state_d = c_ST_WRITE;
            c_ST_WRITE:    state_d = (sym_cnt_inc >= c_T_CNT) ? c_ST_BEST : c_ST_WAIT_SYM;
            c_ST_BEST:     state_d = c_ST_TRACE;
            c_ST_TRACE:    if (trace_cnt_q == c_PTR_ONE) state_d = c_ST_OUTPUT;
            c_ST_OUTPUT: begin
                if (dx_ready) begin
                    state_d = (sym_cnt_q == c_FRAME_CNT) ? c_ST_IDLE : c_ST_WAIT_SYM;
                end
            end
            default:       state_d = c_ST_IDLE;
        endcase
    end

    // Datapath updates: metric/path-memory writes, best-state search, traceback
    always_comb begin
        metric_d     = metric_q;
        col_d        = col_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        trace_cnt_d  = trace_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        tb_state_d   = tb_state_q;
        frame_done_d = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (frame_start) begin
                    metric_d  = c_METRIC_INIT;
                    wr_ptr_d  = '0;
                    sym_cnt_d = '0;
                end
            end
            c_ST_WRITE: begin
                metric_d        = metric_wr;
                col_d[wr_ptr_q] = acs_dec_in;
                wr_ptr_d        = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + c_PTR_ONE;
                sym_cnt_d       = sym_cnt_inc;
            end
            c_ST_BEST: begin
                tb_state_d  = best_idx;
                rd_ptr_d    = (wr_ptr_q == '0) ? c_PTR_LAST : wr_ptr_q - c_PTR_ONE;
                trace_cnt_d = c_PTR_LAST;
            end
            c_ST_TRACE: begin
                tb_state_d  = tb_shift[M:1];
                rd_ptr_d    = (rd_ptr_q == '0) ? c_PTR_LAST : rd_ptr_q - c_PTR_ONE;
                trace_cnt_d = trace_cnt_q - c_PTR_ONE;
            end
            c_ST_OUTPUT: begin
                if (dx_ready && (sym_cnt_q == c_FRAME_CNT)) begin
                    frame_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        sym_ready  = (state_q == c_ST_WAIT_SYM);
        le         = (state_q == c_ST_LOAD);
        ae         = (state_q == c_ST_ADD);
        dx_valid   = (state_q == c_ST_OUTPUT);
        dx         = (state_q == c_ST_OUTPUT) && tb_state_q[0];
        busy       = (state_q != c_ST_IDLE);
        frame_done = frame_done_q;
        metric_out = metric_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_viterbi_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_viterbi_ctrl_gen
// Description : Directed self-checking bench for viterbi_ctrl_gen (K=3, W=4,
//               T=16, FRAME_LEN=40) with a behavioural saturating ACS array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_ctrl_gen;

    localparam int K = 3, W = 4, T = 16, FRAME_LEN = 40, CNT_W = 9;

    logic        clock, reset, frame_start, sym_valid, dx_ready;
    logic        sym_ready, le, ae, dx, dx_valid, busy, frame_done;
    logic [15:0] acs_metric_in, metric_out;
    logic [3:0]  acs_dec_in;

    logic        use_model;
    logic [1:0]  cur_sym;
    logic [15:0] force_m;
    logic [3:0]  force_d;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_cyc   = 0;

    viterbi_ctrl_gen #(.K(K), .W(W), .T(T), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .le(le), .ae(ae),
        .acs_metric_in(acs_metric_in), .acs_dec_in(acs_dec_in),
        .metric_out(metric_out), .dx(dx), .dx_valid(dx_valid),
        .dx_ready(dx_ready), .busy(busy), .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural ACS for the (7,5) code; state LSB is the newest input bit
    function automatic logic [19:0] acs_model(input logic [15:0] prev, input logic [1:0] sym);
        logic [15:0] nm;
        logic [3:0]  nd;
        logic [1:0]  sv, p0, p1, o0, o1, x0, x1;
        logic        u;
        logic [4:0]  c0, c1;
        nm = '0;
        nd = '0;
        for (int s = 0; s < 4; s++) begin
            sv = 2'(s);
            u  = sv[0];
            p0 = {1'b0, sv[1]};
            p1 = {1'b1, sv[1]};
            o0 = {u ^ p0[0] ^ p0[1], u ^ p0[1]};
            o1 = {u ^ p1[0] ^ p1[1], u ^ p1[1]};
            x0 = o0 ^ sym;
            x1 = o1 ^ sym;
            c0 = {1'b0, prev[int'(p0)*4 +: 4]} + 5'(x0[0]) + 5'(x0[1]);
            c1 = {1'b0, prev[int'(p1)*4 +: 4]} + 5'(x1[0]) + 5'(x1[1]);
            if (c0 > 5'd15) c0 = 5'd15;
            if (c1 > 5'd15) c1 = 5'd15;
            if (c1 < c0) begin
                nm[s*4 +: 4] = c1[3:0];
                nd[s]        = 1'b1;
            end else begin
                nm[s*4 +: 4] = c0[3:0];
                nd[s]        = 1'b0;
            end
        end
        return {nd, nm};
    endfunction

    always_comb begin
        if (use_model) {acs_dec_in, acs_metric_in} = acs_model(metric_out, cur_sym);
        else           {acs_dec_in, acs_metric_in} = {force_d, force_m};
    end

    task automatic do_reset;
        reset = 1'b1; frame_start = 1'b0; sym_valid = 1'b0; dx_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic start_frame;
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    // Presents one symbol once sym_ready is seen; records the handshake cycle
    task automatic send_sym(input logic [1:0] s);
        int n;
        n = 0;
        @(negedge clock);
        while (!sym_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sym_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_sym_timeout: sym_ready=%b required=1", sym_ready);
        end else begin
            cur_sym   = s;
            sym_valid = 1'b1;
            hs_cyc    = cyc;
            @(negedge clock);
            sym_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        frame_start = 1'($urandom_range(0, 1));
        sym_valid   = 1'($urandom_range(0, 1));
        dx_ready    = 1'($urandom_range(0, 1));
        use_model   = 1'b0;
        force_m     = 16'($urandom);
        force_d     = 4'($urandom);
        cur_sym     = 2'($urandom);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({sym_ready, le, ae, dx, dx_valid, busy, frame_done} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs: got=%b required=0000000",
                     {sym_ready, le, ae, dx, dx_valid, busy, frame_done});
        end
        checks++;
        if (metric_out !== 16'hFFF0) begin
            failures++;
            $display("FAIL reset_metrics: got=%h required=fff0", metric_out);
        end
        frame_start = 1'b0; sym_valid = 1'b0; dx_ready = 1'b0; reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, sym_ready, dx_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle: busy/sym_ready/dx_valid=%b required=000", {busy, sym_ready, dx_valid});
        end
    endtask

    task automatic test_frame;
        logic [39:0] bits;
        logic [1:0]  p;
        logic        u;
        int sent, got, done_cnt, done_cyc, acc_last, first_dx, hs15, n;
        do_reset();
        use_model = 1'b1;
        dx_ready  = 1'b1;
        p         = 2'b00;
        for (int i = 0; i < 40; i++) bits[i] = (i < 38) ? 1'($urandom_range(0, 1)) : 1'b0;
        start_frame();
        sent = 0; got = 0; done_cnt = 0; done_cyc = -1; acc_last = -100;
        first_dx = -1; hs15 = -1; n = 0;
        while (n < 3000) begin
            @(negedge clock);
            n++;
            if (frame_done) begin
                done_cnt++;
                done_cyc = n;
            end
            if (dx_valid) begin
                if (first_dx < 0) first_dx = n;
                if (got < 40) begin
                    checks++;
                    if (dx !== bits[got]) begin
                        failures++;
                        $display("FAIL frame_dx[%0d]: dx=%b required=%b", got, dx, bits[got]);
                    end
                end
                got++;
                if (got == 25) acc_last = n;
            end
            if (sym_ready && sent < 40) begin
                u         = bits[sent];
                cur_sym   = {u ^ p[0] ^ p[1], u ^ p[1]};
                p         = {p[0], u};
                sym_valid = 1'b1;
                if (sent == 15) hs15 = n;
                sent++;
            end else begin
                sym_valid = 1'b0;
            end
            if (got >= 25 && n >= acc_last + 4) break;
        end
        sym_valid = 1'b0;
        checks++;
        if (got != 25) begin
            failures++;
            $display("FAIL frame_count: decoded=%0d required=25", got);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL frame_done_count: pulses=%0d required=1", done_cnt);
        end
        checks++;
        if (done_cyc != acc_last + 1) begin
            failures++;
            $display("FAIL frame_done_timing: cycle=%0d required=%0d", done_cyc, acc_last + 1);
        end
        checks++;
        if (first_dx - hs15 != T + 4) begin
            failures++;
            $display("FAIL dx_latency: cycles=%0d required=%0d", first_dx - hs15, T + 4);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_end_idle: busy=%b required=0", busy);
        end
        use_model = 1'b0;
        dx_ready  = 1'b0;
    endtask

    task automatic test_norm;
        logic [15:0] exp_m;
`ifdef VITERBI_METRIC_NORM_EN
        exp_m = 16'h7420;
`else
        exp_m = 16'hC975;
`endif
        do_reset();
        use_model = 1'b0;
        force_m   = 16'hC975;
        force_d   = 4'b0000;
        start_frame();
        send_sym(2'b00);
        for (int i = 0; i < 10 && !sym_ready; i++) @(negedge clock);
        checks++;
        if (metric_out !== exp_m) begin
            failures++;
            $display("FAIL norm_metrics: got=%h required=%h", metric_out, exp_m);
        end
    endtask

    task automatic test_best_tie;
        int n;
        do_reset();
        use_model = 1'b0;
        force_m   = 16'h5555;
        force_d   = 4'b0110;
        dx_ready  = 1'b0;
        start_frame();
        for (int i = 0; i < 16; i++) send_sym(2'b00);
        n = 0;
        while (!dx_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (dx_valid !== 1'b1) begin
            failures++;
            $display("FAIL best_tie_timeout: dx_valid=%b required=1", dx_valid);
        end
        checks++;
        if (cyc - hs_cyc != T + 4) begin
            failures++;
            $display("FAIL best_tie_latency: cycles=%0d required=%0d", cyc - hs_cyc, T + 4);
        end
        checks++;
        if (dx !== 1'b0) begin
            failures++;
            $display("FAIL best_tie_dx: dx=%b required=0", dx);
        end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if ({dx_valid, dx, sym_ready} !== 3'b100) begin
                failures++;
                $display("FAIL hold[%0d]: dx_valid/dx/sym_ready=%b required=100", i, {dx_valid, dx, sym_ready});
            end
        end
        dx_ready = 1'b1;
        @(negedge clock);
        dx_ready = 1'b0;
        checks++;
        if ({sym_ready, dx_valid} !== 2'b10) begin
            failures++;
            $display("FAIL hold_accept: sym_ready/dx_valid=%b required=10", {sym_ready, dx_valid});
        end
    endtask

    task automatic test_best_unique;
        int n;
        force_m = 16'h3116;
        send_sym(2'b00);
        n = 0;
        while (!dx_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if ({dx_valid, dx} !== 2'b11) begin
            failures++;
            $display("FAIL best_unique_dx: dx_valid/dx=%b required=11", {dx_valid, dx});
        end
        dx_ready = 1'b1;
        @(negedge clock);
        dx_ready = 1'b0;
    endtask

    task automatic test_frame_start_busy;
        int n;
        do_reset();
        use_model = 1'b0;
        force_m   = 16'h3210;
        force_d   = 4'b0110;
        dx_ready  = 1'b1;
        start_frame();
        for (int i = 0; i < 14; i++) send_sym(2'b00);
        for (int i = 0; i < 10 && !sym_ready; i++) @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        checks++;
        if ({busy, sym_ready} !== 2'b11 || metric_out !== 16'h3210) begin
            failures++;
            $display("FAIL busy_frame_start: busy/sym_ready=%b metrics=%h required=11 3210",
                     {busy, sym_ready}, metric_out);
        end
        send_sym(2'b00);
        send_sym(2'b00);
        n = 0;
        while (!dx_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (dx_valid !== 1'b1 || cyc - hs_cyc != T + 4) begin
            failures++;
            $display("FAIL busy_sym_cnt: dx_valid=%b latency=%0d required=1 %0d",
                     dx_valid, cyc - hs_cyc, T + 4);
        end
        dx_ready = 1'b0;
    endtask

    task automatic test_reset_in_trace;
        int seen;
        do_reset();
        use_model = 1'b0;
        force_m   = 16'h3210;
        force_d   = 4'b0110;
        dx_ready  = 1'b1;
        start_frame();
        for (int i = 0; i < 16; i++) send_sym(2'b00);
        repeat (6) @(negedge clock);
        checks++;
        if ({busy, dx_valid, sym_ready} !== 3'b100) begin
            failures++;
            $display("FAIL trace_state: busy/dx_valid/sym_ready=%b required=100", {busy, dx_valid, sym_ready});
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, dx_valid, dx, sym_ready, le, ae} !== 6'b0 || metric_out !== 16'hFFF0) begin
            failures++;
            $display("FAIL trace_reset: flags=%b metrics=%h required=000000 fff0",
                     {busy, dx_valid, dx, sym_ready, le, ae}, metric_out);
        end
        reset = 1'b0;
        seen  = 0;
        repeat (25) begin
            @(negedge clock);
            if (dx_valid || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL trace_reset_quiet: active_cycles=%0d required=0", seen);
        end
        dx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_norm();
        test_best_tie();
        test_hold();
        test_best_unique();
        test_frame_start_busy();
        test_reset_in_trace();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
